// File: rtl/acq_range_sequencer_pkg.sv
// Shared types and constants for the acquisition range sequencer.
// Range thresholds are bit positions below the MSB of the converter word.
package acq_pkg;

    localparam int unsigned RANGE_W           = 2;
    localparam int unsigned TH_HI             = 6;
    localparam int unsigned TH_MID            = 4;
    localparam int unsigned TH_LO             = 2;
    localparam int          DEF_SAMPLE_DIV    = 500;
    localparam int          DEF_SETTLE_CYCLES = 1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIAP_START,
        ST_DIAP_WAIT,
        ST_SETTLE,
        ST_RES_START,
        ST_RES_WAIT,
        ST_PUBLISH
    } acq_state_e;

    // Small signals need the most gain: code 3 is the highest gain.
    function automatic logic [RANGE_W-1:0] range_code(input logic [63:0] v, input int unsigned w);
        if ((v >> (w - TH_HI)) == 64'd0)       return 2'd3;
        else if ((v >> (w - TH_MID)) == 64'd0) return 2'd2;
        else if ((v >> (w - TH_LO)) == 64'd0)  return 2'd1;
        else                                   return 2'd0;
    endfunction

endpackage

// File: rtl/acq_range_sequencer_if.sv
// Converter / front-end / result bus of the acquisition range sequencer.
// master = sequencer side, slave = converter and consumer side.
interface acq_range_sequencer_if
    import acq_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int DIAP_WIDTH = RANGE_W
);
    logic                  enable;
    logic                  busy;
    logic                  sample_adc;
    logic                  start_cycle_conv;
    logic                  read_diapason;
    logic                  complete;
    logic [DATA_WIDTH-1:0] data_in_1, data_in_2;
    logic [DIAP_WIDTH-1:0] gain_1, gain_2;
    logic [DATA_WIDTH-1:0] result_1, result_2;
    logic [DIAP_WIDTH-1:0] range_1, range_2;
    logic                  result_valid;
    logic                  timeout_err;

    modport master (
        input  enable, complete, data_in_1, data_in_2,
        output busy, sample_adc, start_cycle_conv, read_diapason, gain_1, gain_2,
               result_1, result_2, range_1, range_2, result_valid, timeout_err
    );

    modport slave (
        output enable, complete, data_in_1, data_in_2,
        input  busy, sample_adc, start_cycle_conv, read_diapason, gain_1, gain_2,
               result_1, result_2, range_1, range_2, result_valid, timeout_err
    );
endinterface

// File: rtl/acq_range_sequencer_clkgen.sv
// Sample square-wave generator: toggles every DIV enabled cycles, forced low
// and re-phased whenever disabled or restarted.
module acq_sample_clkgen
    import acq_pkg::*;
#(
    parameter int DIV = DEF_SAMPLE_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic restart_i,
    output logic sample_o
);
    logic [31:0] cnt_q, cnt_d;
    logic        ph_q, ph_d;

    always_comb begin
        cnt_d = cnt_q + 32'd1;
        ph_d  = ph_q;
        if (restart_i || !en_i) begin
            cnt_d = '0;
            ph_d  = 1'b0;
        end else if (cnt_q == 32'(DIV - 1)) begin
            cnt_d = '0;
            ph_d  = ~ph_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ph_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ph_q  <= ph_d;
        end
    end

    // Gate so the output is low on the very first idle cycle too.
    assign sample_o = ph_q & en_i;
endmodule

// File: rtl/acq_range_sequencer.sv
// Two-pass acquisition: measure range, set front-end gain, settle, convert, publish.
// Define ACQ_TIMEOUT_EN to add a watchdog on the converter-wait states.
module acq_range_sequencer
    import acq_pkg::*;
#(
    parameter int DATA_WIDTH     = 24,
    parameter int DIAP_WIDTH     = RANGE_W,
    parameter int SAMPLE_DIV     = DEF_SAMPLE_DIV,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = 2**22
) (
    input logic                   clk,
    input logic                   rst,
    acq_range_sequencer_if.master bus
);
    acq_state_e            state_q, state_d;
    logic [31:0]           cnt_q, cnt_d;
    logic                  cmp_q, rise, tmo, in_wait;
    logic [DIAP_WIDTH-1:0] gain_1_q, gain_1_d, gain_2_q, gain_2_d;
    logic [DIAP_WIDTH-1:0] range_1_q, range_1_d, range_2_q, range_2_d;
    logic [DATA_WIDTH-1:0] res_1_q, res_1_d, res_2_q, res_2_d;
    logic                  busy, scc, rdiap, rvalid, sample;

    assign rise    = bus.complete & ~cmp_q;
    assign in_wait = (state_q == ST_DIAP_WAIT) || (state_q == ST_RES_WAIT);

`ifdef ACQ_TIMEOUT_EN
    logic [31:0] wdog_q, wdog_d;
    assign tmo    = in_wait && !rise && (wdog_q == 32'(TIMEOUT_CYCLES - 1));
    assign wdog_d = (in_wait && state_d == state_q) ? wdog_q + 32'd1 : '0;
    always_ff @(posedge clk) begin
        if (rst) wdog_q <= '0;
        else     wdog_q <= wdog_d;
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cmp_q     <= 1'b0;
            gain_1_q  <= '0;
            gain_2_q  <= '0;
            range_1_q <= '0;
            range_2_q <= '0;
            res_1_q   <= '0;
            res_2_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmp_q     <= bus.complete;
            gain_1_q  <= gain_1_d;
            gain_2_q  <= gain_2_d;
            range_1_q <= range_1_d;
            range_2_q <= range_2_d;
            res_1_q   <= res_1_d;
            res_2_q   <= res_2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:       if (bus.enable) state_d = ST_DIAP_START;
            ST_DIAP_START: if (cnt_q == 32'd1) state_d = ST_DIAP_WAIT;
            ST_DIAP_WAIT:  if (rise) state_d = ST_SETTLE;
                           else if (tmo) state_d = ST_IDLE;
            ST_SETTLE:     if (cnt_q == 32'(SETTLE_CYCLES - 1)) state_d = ST_RES_START;
            ST_RES_START:  if (cnt_q == 32'd1) state_d = ST_RES_WAIT;
            ST_RES_WAIT:   if (rise) state_d = ST_PUBLISH;
                           else if (tmo) state_d = ST_IDLE;
            ST_PUBLISH:    state_d = bus.enable ? ST_DIAP_START : ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
        // One counter serves both the start pulse width and the settle time.
        cnt_d = (state_d == state_q && !in_wait && state_q != ST_IDLE) ? cnt_q + 32'd1 : '0;
    end

    always_comb begin
        gain_1_d  = gain_1_q;
        gain_2_d  = gain_2_q;
        range_1_d = range_1_q;
        range_2_d = range_2_q;
        res_1_d   = res_1_q;
        res_2_d   = res_2_q;
        if (state_q == ST_DIAP_WAIT && rise) begin
            gain_1_d = DIAP_WIDTH'(range_code(64'(bus.data_in_1), DATA_WIDTH));
            gain_2_d = DIAP_WIDTH'(range_code(64'(bus.data_in_2), DATA_WIDTH));
        end
        if (state_q == ST_RES_WAIT && rise) begin
            res_1_d   = bus.data_in_1;
            res_2_d   = bus.data_in_2;
            range_1_d = gain_1_q;
            range_2_d = gain_2_q;
        end
        if (tmo) begin
            gain_1_d = '0;
            gain_2_d = '0;
        end
    end

    always_comb begin
        busy   = (state_q != ST_IDLE);
        scc    = (state_q == ST_DIAP_START) || (state_q == ST_RES_START);
        rdiap  = (state_q == ST_DIAP_START) || (state_q == ST_DIAP_WAIT);
        rvalid = (state_q == ST_PUBLISH);
    end

    acq_sample_clkgen #(.DIV(SAMPLE_DIV)) u_clkgen (
        .clk       (clk),
        .rst       (rst),
        .en_i      (busy),
        .restart_i (state_q == ST_IDLE),
        .sample_o  (sample)
    );

    assign bus.busy             = busy;
    assign bus.start_cycle_conv = scc;
    assign bus.read_diapason    = rdiap;
    assign bus.result_valid     = rvalid;
    assign bus.timeout_err      = tmo;
    assign bus.sample_adc       = sample;
    assign bus.gain_1           = gain_1_q;
    assign bus.gain_2           = gain_2_q;
    assign bus.range_1          = range_1_q;
    assign bus.range_2          = range_2_q;
    assign bus.result_1         = res_1_q;
    assign bus.result_2         = res_2_q;
endmodule

// File: tb/tb_acq_range_sequencer.sv
// Directed bench for acq_range_sequencer with a phase-level reference model
// compared every cycle, plus literal spot checks. Honours ACQ_TIMEOUT_EN.
module tb_acq_range_sequencer;
    localparam int DW = 24, GW = 2, DIV = 4, SETTLE = 10, TMO = 64;
    localparam int P_IDLE = 0, P_DS = 1, P_DW = 2, P_ST = 3, P_RS = 4, P_RW = 5, P_PUB = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    acq_range_sequencer_if #(.DATA_WIDTH(DW), .DIAP_WIDTH(GW)) bus ();

    acq_range_sequencer #(
        .DATA_WIDTH(DW), .DIAP_WIDTH(GW), .SAMPLE_DIV(DIV),
        .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0, fails = 0, rv_seen = 0, tmo_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [GW-1:0] code_of(input logic [DW-1:0] d);
        if (d < 24'h040000) return 2'd3;
        if (d < 24'h100000) return 2'd2;
        if (d < 24'h400000) return 2'd1;
        return 2'd0;
    endfunction

    // Reference model: phase, cycles spent in phase, busy-cycle index.
    int              m_ph = 0, m_n = 0, m_k = 0;
    bit              m_ok = 0;
    logic            m_prev = 1'b0;
    logic [GW-1:0]   m_g1 = '0, m_g2 = '0, m_r1 = '0, m_r2 = '0;
    logic [DW-1:0]   m_res1 = '0, m_res2 = '0;

    function automatic bit exp_tmo();
`ifdef ACQ_TIMEOUT_EN
        return (m_ph == P_DW || m_ph == P_RW) && m_n == TMO - 1 && !(bus.complete && !m_prev);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        automatic int nph  = m_ph;
        automatic bit rise = bus.complete && !m_prev;
        automatic bit tmo  = exp_tmo();
        if (rst) begin
            m_ok <= 1; m_ph <= P_IDLE; m_n <= 0; m_k <= 0; m_prev <= 1'b0;
            m_g1 <= '0; m_g2 <= '0; m_r1 <= '0; m_r2 <= '0; m_res1 <= '0; m_res2 <= '0;
        end else begin
            case (m_ph)
                P_IDLE: if (bus.enable) nph = P_DS;
                P_DS:   if (m_n == 1) nph = P_DW;
                P_DW:   if (rise) begin
                            nph = P_ST;
                            m_g1 <= code_of(bus.data_in_1);
                            m_g2 <= code_of(bus.data_in_2);
                        end else if (tmo) begin
                            nph = P_IDLE; m_g1 <= '0; m_g2 <= '0;
                        end
                P_ST:   if (m_n == SETTLE - 1) nph = P_RS;
                P_RS:   if (m_n == 1) nph = P_RW;
                P_RW:   if (rise) begin
                            nph = P_PUB;
                            m_res1 <= bus.data_in_1; m_res2 <= bus.data_in_2;
                            m_r1 <= m_g1; m_r2 <= m_g2;
                        end else if (tmo) begin
                            nph = P_IDLE; m_g1 <= '0; m_g2 <= '0;
                        end
                default: nph = bus.enable ? P_DS : P_IDLE;
            endcase
            m_k    <= (m_ph == P_IDLE) ? 0 : m_k + 1;
            m_n    <= (nph == m_ph) ? m_n + 1 : 0;
            m_ph   <= nph;
            m_prev <= bus.complete;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("busy",          32'(bus.busy),             32'(m_ph != P_IDLE));
            chk("start_conv",    32'(bus.start_cycle_conv), 32'(m_ph == P_DS || m_ph == P_RS));
            chk("read_diapason", 32'(bus.read_diapason),    32'(m_ph == P_DS || m_ph == P_DW));
            chk("result_valid",  32'(bus.result_valid),     32'(m_ph == P_PUB));
            chk("timeout_err",   32'(bus.timeout_err),      32'(exp_tmo()));
            chk("sample_adc",    32'(bus.sample_adc),       32'(m_ph != P_IDLE && ((m_k / DIV) % 2) == 1));
            chk("gain_1",        32'(bus.gain_1),   32'(m_g1));
            chk("gain_2",        32'(bus.gain_2),   32'(m_g2));
            chk("range_1",       32'(bus.range_1),  32'(m_r1));
            chk("range_2",       32'(bus.range_2),  32'(m_r2));
            chk("result_1",      32'(bus.result_1), 32'(m_res1));
            chk("result_2",      32'(bus.result_2), 32'(m_res2));
            if (bus.result_valid) rv_seen++;
            if (bus.timeout_err)  tmo_seen++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input logic rd, input string nm);
        int i;
        for (i = 0; i < 200; i++) begin
            if (bus.start_cycle_conv && bus.read_diapason == rd) break;
            tick();
        end
        chk(nm, 32'(i < 200), 32'd1);
    endtask

    // Converter reply 20 cycles after start, as a one-cycle complete pulse.
    task automatic convert(input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic rd, input string nm);
        wait_start(rd, nm);
        tick(20);
        bus.data_in_1 = d1;
        bus.data_in_2 = d2;
        bus.complete  = 1'b1;
        tick();
        bus.complete  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout at %0t: got running expected finished", $time);
        $fatal(1, "bench time limit");
    end

    initial begin
        bus.enable = 1'b0; bus.complete = 1'b0; bus.data_in_1 = '0; bus.data_in_2 = '0;
        tick(3);
        rst = 1'b0;
        chk("rst_busy",     32'(bus.busy),       32'd0);
        chk("rst_sample",   32'(bus.sample_adc), 32'd0);
        chk("rst_result_1", 32'(bus.result_1),   32'd0);

        // Continuous acquisition, first cycle
        bus.enable = 1'b1;
        convert(24'h000100, 24'hF00000, 1'b1, "start_diap_1");
        chk("lit_gain_1a", 32'(bus.gain_1), 32'd3);
        chk("lit_gain_2a", 32'(bus.gain_2), 32'd0);
        convert(24'h123456, 24'h000010, 1'b0, "start_res_1");
        chk("lit_rv_1",      32'(bus.result_valid), 32'd1);
        chk("lit_result_1",  32'(bus.result_1), 32'h123456);
        chk("lit_range_1a",  32'(bus.range_1),  32'd3);
        chk("lit_range_2a",  32'(bus.range_2),  32'd0);
        tick();
        chk("lit_rv_1_drop", 32'(bus.result_valid), 32'd0);

        // Second cycle runs back-to-back; enable drops during SETTLE
        convert(24'h040000, 24'h3FFFFF, 1'b1, "start_diap_2");
        chk("lit_gain_1b", 32'(bus.gain_1), 32'd2);
        chk("lit_gain_2b", 32'(bus.gain_2), 32'd1);
        bus.enable = 1'b0;
        convert(24'hABCDEF, 24'h000001, 1'b0, "start_res_2");
        chk("lit_rv_2",     32'(bus.result_valid), 32'd1);
        chk("lit_result_2", 32'(bus.result_1), 32'hABCDEF);
        chk("lit_range_1b", 32'(bus.range_1),  32'd2);
        chk("lit_range_2b", 32'(bus.range_2),  32'd1);
        tick();
        chk("lit_idle_busy",   32'(bus.busy),       32'd0);
        chk("lit_idle_sample", 32'(bus.sample_adc), 32'd0);

        // A complete edge while idle does nothing
        bus.complete = 1'b1;
        tick();
        bus.complete = 1'b0;
        tick(3);
        chk("lit_idle_edge_busy", 32'(bus.busy), 32'd0);

        // complete already high when RES_WAIT is entered
        bus.enable = 1'b1;
        convert(24'h000100, 24'h000100, 1'b1, "start_diap_3");
        bus.enable   = 1'b0;
        bus.complete = 1'b1;
        wait_start(1'b0, "start_res_3");
        tick(2 + TMO + 4);
`ifdef ACQ_TIMEOUT_EN
        chk("lit_tmo_count", 32'(tmo_seen), 32'd1);
        chk("lit_tmo_busy",  32'(bus.busy), 32'd0);
        chk("lit_tmo_gain",  32'(bus.gain_1), 32'd0);
        bus.complete = 1'b0;
        bus.enable   = 1'b1;
        convert(24'h000100, 24'h000100, 1'b1, "start_diap_4");
        bus.enable = 1'b0;
        wait_start(1'b0, "start_res_4");
        tick(5);
`else
        chk("lit_stuck_busy", 32'(bus.busy), 32'd1);
        chk("lit_stuck_tmo",  32'(tmo_seen), 32'd0);
        chk("lit_stuck_rd",   32'(bus.read_diapason), 32'd0);
        bus.complete = 1'b0;
        tick(3);
`endif
        // Reset while waiting for the result conversion
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("lit_rst_busy",    32'(bus.busy),             32'd0);
        chk("lit_rst_start",   32'(bus.start_cycle_conv), 32'd0);
        chk("lit_rst_rv",      32'(bus.result_valid),     32'd0);
        chk("lit_rst_result",  32'(bus.result_1),         32'd0);
        chk("lit_rst_gain",    32'(bus.gain_1),           32'd0);
        chk("lit_rst_range",   32'(bus.range_1),          32'd0);
        tick(3);
        chk("lit_rv_total", 32'(rv_seen), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/acq_range_sequencer.md
ACQ_RANGE_SEQUENCER -- requirements
Module: acq_range_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 24, result width per channel; DIAP_WIDTH, 2, range code width; SAMPLE_DIV, 500, clk cycles per sample_adc half-period; SETTLE_CYCLES, 1000, gain-settle wait; TIMEOUT_CYCLES, 2^22, watchdog limit.
REQ-002 Ports SHALL be: clk in 1 clock (one clock, all logic on rising edge); rst in 1 reset, synchronous, active-high.
REQ-003 Ports: enable in 1 run continuous acquisition; busy out 1 cycle in progress.
REQ-004 Ports: sample_adc out 1 sample square wave; start_cycle_conv out 1 cycle start; read_diapason out 1 range-measure select; complete in 1 converter done level.
REQ-005 Ports: data_in_1, data_in_2 in DATA_WIDTH converter results; gain_1, gain_2 out DIAP_WIDTH range codes to front end.
REQ-006 Ports: result_1, result_2 out DATA_WIDTH published results; range_1, range_2 out DIAP_WIDTH codes tagging results; result_valid out 1 one-cycle publish strobe; timeout_err out 1 one-cycle watchdog strobe.

Function
REQ-007 States SHALL be IDLE, DIAP_START, DIAP_WAIT, SETTLE, RES_START, RES_WAIT, PUBLISH.
REQ-008 IDLE -> DIAP_START when enable=1; otherwise stay, busy=0.
REQ-009 DIAP_START: read_diapason=1, start_cycle_conv=1 for exactly 2 cycles, then DIAP_WAIT.
REQ-010 DIAP_WAIT: on complete rising edge (complete=1, previous cycle 0), latch range codes per channel into gain_x, go SETTLE.
REQ-011 Range code from unsigned data_in_x: 3 if < 2^(DATA_WIDTH-6); 2 if < 2^(DATA_WIDTH-4); 1 if < 2^(DATA_WIDTH-2); else 0.
REQ-012 SETTLE: count SETTLE_CYCLES cycles, then RES_START.
REQ-013 RES_START: read_diapason=0, start_cycle_conv=1 for 2 cycles, then RES_WAIT.
REQ-014 RES_WAIT: on complete rising edge, latch data_in_x into result_x and gain_x into range_x, go PUBLISH.
REQ-015 PUBLISH: result_valid=1 for one cycle; next state DIAP_START if enable=1, else IDLE.
REQ-016 read_diapason SHALL be held stable from DIAP_START through DIAP_WAIT and from RES_START through RES_WAIT.
REQ-017 sample_adc SHALL toggle every SAMPLE_DIV cycles whenever busy=1; held 0 in IDLE; phase counter restarts at 0 on IDLE exit.
REQ-018 busy=1 in every state except IDLE.
REQ-019 enable deasserted mid-cycle SHALL NOT abort; cycle completes, publishes, then IDLE.
REQ-020 complete already high on entry to a WAIT state SHALL NOT count; only a fresh rising edge advances.
REQ-021 complete rising edge outside WAIT states SHALL be ignored.

Reset
REQ-022 On rst=1 at clk edge: state IDLE; sample_adc, start_cycle_conv, read_diapason, result_valid, timeout_err, busy = 0; result_x = 0; gain_x, range_x = 0 (lowest gain); all counters 0.
REQ-023 rst asserted mid-cycle SHALL abort immediately with no result_valid.

Configuration
REQ-024 Macro ACQ_TIMEOUT_EN defined: watchdog counts cycles in DIAP_WAIT/RES_WAIT; at TIMEOUT_CYCLES without complete edge, pulse timeout_err one cycle, force gain_x=0, go IDLE.
REQ-025 ACQ_TIMEOUT_EN undefined: no watchdog counter; timeout_err tied 0; WAIT states wait indefinitely.

Structure
REQ-026 Shared package acq_pkg SHALL hold state enum, range code width, range threshold exponents (6, 4, 2), default SAMPLE_DIV/SETTLE_CYCLES.
REQ-027 Sub-module acq_sample_clkgen SHALL generate sample_adc (divider with enable and synchronous restart).

Verification
REQ-028 enable=1, SAMPLE_DIV=4, model returns complete 20 cycles after start -> start_cycle_conv 2-cycle pulses, read_diapason 1 then 0, sample_adc period 8 cycles.
REQ-029 diap data_in_1=0x000100, data_in_2=0xF00000 -> gain_1=3, gain_2=0; result publish range_1=3, range_2=0.
REQ-030 result data_in_1=0x123456 -> result_1=0x123456, result_valid high exactly 1 cycle.
REQ-031 enable dropped during SETTLE -> cycle finishes, one result_valid, then IDLE, busy=0, sample_adc=0.
REQ-032 complete held high entering RES_WAIT, no new edge, ACQ_TIMEOUT_EN, TIMEOUT_CYCLES=64 -> timeout_err after 64 cycles, gain_x=0, IDLE; without macro -> stays RES_WAIT.
REQ-033 rst pulsed in RES_WAIT -> next cycle all outputs at REQ-022 values, no result_valid.
